net_msg_queue: RTL and testbench

NET_MSG_QUEUE -- requirements
Module: net_msg_queue

---
 rtl/net_msg_pkg.sv | 27 ++
 rtl/net_msg_queue_if.sv | 25 ++
 rtl/net_msg_fifo.sv | 57 +++++
 rtl/net_msg_queue.sv | 124 ++++++++++++
 tb/tb_net_msg_queue.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/net_msg_pkg.sv
// Shared definitions for the network message queue: message layout and head FSM states.
package net_msg_pkg;

    localparam int NET_MSG_W     = 122;
    localparam int CPL_LSB       = 120;
    localparam int CPL_W         = 2;
    localparam int TGT_PSO_LSB   = 96;
    localparam int TASK_ID_LSB   = 80;
    localparam int PROC_INDX_LSB = 64;
    localparam int PARAM_LSB     = 32;
    localparam int SRC_PSO_LSB   = 0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_GAP     = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        PRESENT = ST_PRESENT,
        GAP     = ST_GAP
    } head_state_e;

    function automatic logic [CPL_W-1:0] msg_cpl(input logic [NET_MSG_W-1:0] msg);
        return msg[CPL_LSB +: CPL_W];
    endfunction

endpackage

// File: rtl/net_msg_queue_if.sv
// Link between the network write side and the messenger read side of the message queue.
interface net_msg_queue_if #(parameter int DEPTH = 8);
    import net_msg_pkg::*;

    logic                     INSTB;
    logic [NET_MSG_W-1:0]     INDATA;
    logic                     INRDY;
    logic                     NETREQ;
    logic [NET_MSG_W-1:0]     NETPARAM;
    logic                     NETMSGRD;
    logic                     OVFL;
    logic [7:0]               DROPCNT;
    logic [$clog2(DEPTH):0]   LEVEL;

    modport master (
        output INSTB, INDATA, NETMSGRD,
        input  INRDY, NETREQ, NETPARAM, OVFL, DROPCNT, LEVEL
    );

    modport slave (
        input  INSTB, INDATA, NETMSGRD,
        output INRDY, NETREQ, NETPARAM, OVFL, DROPCNT, LEVEL
    );

endinterface

// File: rtl/net_msg_fifo.sv
// Synchronous show-ahead FIFO; a push while full is taken only when a pop frees a slot at the same edge.
module net_msg_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 122
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LEVEL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/net_msg_queue.sv
// Network message queue: a FIFO feeding a head register presented to the messenger.
// Define NETQ_PRIORITY_EN to add a 2-entry queue for CPL==0 messages that is served first.
module net_msg_queue #(
    parameter int DEPTH = 8
) (
    input logic             CLK,
    input logic             RESETn,
    net_msg_queue_if.slave  bus
);
    import net_msg_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;

    head_state_e          state;
    logic [NET_MSG_W-1:0] head;
    logic [NET_MSG_W-1:0] main_rdata;
    logic [NET_MSG_W-1:0] load_data;
    logic [LW-1:0]        main_level;
    logic                 main_full;
    logic                 main_empty;
    logic                 main_push;
    logic                 main_pop;
    logic                 main_drop;
    logic                 prio_empty;
    logic                 prio_drop;
    logic                 head_load;
    logic                 drop;
    logic                 ovfl;
    logic [7:0]           drop_cnt;

    assign head_load = (state == IDLE) && (!main_empty || !prio_empty);

`ifdef NETQ_PRIORITY_EN
    logic                 prio_sel;
    logic                 prio_pop;
    logic                 prio_full;
    logic [NET_MSG_W-1:0] prio_rdata;
    logic [1:0]           unused_prio_level;

    assign prio_sel  = (msg_cpl(bus.INDATA) == 2'd0);
    assign main_push = bus.INSTB && !prio_sel;
    assign prio_pop  = head_load && !prio_empty;
    assign main_pop  = head_load && prio_empty;
    assign load_data = prio_empty ? main_rdata : prio_rdata;
    assign prio_drop = bus.INSTB && prio_sel && prio_full && !prio_pop;

    net_msg_fifo #(.DEPTH(2), .WIDTH(NET_MSG_W)) u_prio_fifo (
        .clk   (CLK),
        .rst_n (RESETn),
        .push  (bus.INSTB && prio_sel),
        .pop   (prio_pop),
        .wdata (bus.INDATA),
        .rdata (prio_rdata),
        .full  (prio_full),
        .empty (prio_empty),
        .level (unused_prio_level)
    );
`else
    assign main_push  = bus.INSTB;
    assign main_pop   = head_load;
    assign load_data  = main_rdata;
    assign prio_empty = 1'b1;
    assign prio_drop  = 1'b0;
`endif

    net_msg_fifo #(.DEPTH(DEPTH), .WIDTH(NET_MSG_W)) u_main_fifo (
        .clk   (CLK),
        .rst_n (RESETn),
        .push  (main_push),
        .pop   (main_pop),
        .wdata (bus.INDATA),
        .rdata (main_rdata),
        .full  (main_full),
        .empty (main_empty),
        .level (main_level)
    );

    assign main_drop = main_push && main_full && !main_pop;
    assign drop      = main_drop || prio_drop;

    // Head only loads from IDLE, so a presented message never changes under the messenger.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
            head  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (head_load) begin
                        head  <= load_data;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.NETMSGRD) begin
                        state <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            ovfl     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ovfl <= drop;
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign bus.INRDY    = !main_full;
    assign bus.NETREQ   = (state == PRESENT);
    assign bus.NETPARAM = head;
    assign bus.OVFL     = ovfl;
    assign bus.DROPCNT  = drop_cnt;
    assign bus.LEVEL    = main_level;

endmodule

// File: tb/tb_net_msg_queue.sv
// Bench for net_msg_queue: directed scenarios and random traffic compared against a queue-based model.
module tb_net_msg_queue;
    import net_msg_pkg::*;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef NETQ_PRIORITY_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic CLK    = 1'b0;
    logic RESETn = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    net_msg_queue_if #(.DEPTH(DEPTH)) bus();

    net_msg_queue #(.DEPTH(DEPTH)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: message queues plus whether a head is presented or in its post-read gap.
    logic [NET_MSG_W-1:0] mq[$];
    logic [NET_MSG_W-1:0] pq[$];
    logic [NET_MSG_W-1:0] m_head;
    bit                   m_present;
    bit                   m_gap;
    bit                   m_ovfl;
    int                   m_drops;

    function automatic bit to_prio(input logic [NET_MSG_W-1:0] d);
        return PRIO_EN && (d[121:120] == 2'd0);
    endfunction

    function automatic logic [NET_MSG_W-1:0] rand_msg(input logic [1:0] cpl);
        logic [NET_MSG_W-1:0] m;
        m[31:0]    = $urandom;
        m[63:32]   = $urandom;
        m[95:64]   = $urandom;
        m[119:96]  = 24'($urandom);
        m[121:120] = cpl;
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        pq.delete();
        m_head    = '0;
        m_present = 1'b0;
        m_gap     = 1'b0;
        m_ovfl    = 1'b0;
        m_drops   = 0;
    endtask

    task automatic model_edge(input bit wr, input logic [NET_MSG_W-1:0] d, input bit rd);
        bit load;
        bit use_p;
        bit dropped;
        load    = !m_present && !m_gap && (mq.size() > 0 || pq.size() > 0);
        use_p   = load && (pq.size() > 0);
        dropped = 1'b0;
        if (wr) begin
            if (to_prio(d)) dropped = (pq.size() == 2) && !use_p;
            else            dropped = (mq.size() == DEPTH) && !(load && !use_p);
        end
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_present && rd) begin
            m_present = 1'b0;
            m_gap     = 1'b1;
        end
        if (load) begin
            m_head    = use_p ? pq.pop_front() : mq.pop_front();
            m_present = 1'b1;
        end
        if (wr && !dropped) begin
            if (to_prio(d)) pq.push_back(d);
            else            mq.push_back(d);
        end
        m_ovfl = dropped;
        if (dropped && m_drops < 255) m_drops++;
    endtask

    task automatic drive(input bit wr, input logic [NET_MSG_W-1:0] d, input bit rd);
        bus.INSTB    = wr;
        bus.INDATA   = d;
        bus.NETMSGRD = rd;
        @(posedge CLK);
        model_edge(wr, d, rd);
        #1;
        bus.INSTB    = 1'b0;
        bus.NETMSGRD = 1'b0;
    endtask

    task automatic do_reset();
        bus.INSTB    = 1'b0;
        bus.NETMSGRD = 1'b0;
        bus.INDATA   = '0;
        RESETn       = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RESETn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (bus.NETREQ !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_netreq: got %b expected 0", bus.NETREQ); end
        tests_run++; if (bus.NETPARAM !== '0) begin tests_failed++; $display("[TB] FAIL reset_netparam: got %h expected 0", bus.NETPARAM); end
        tests_run++; if (bus.OVFL !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ovfl: got %b expected 0", bus.OVFL); end
        tests_run++; if (bus.DROPCNT !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_dropcnt: got %0d expected 0", bus.DROPCNT); end
        tests_run++; if (bus.LEVEL !== LW'(0)) begin tests_failed++; $display("[TB] FAIL reset_level: got %0d expected 0", bus.LEVEL); end
        tests_run++; if (bus.INRDY !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_inrdy: got %b expected 1", bus.INRDY); end
    endtask

    task automatic test_single();
        logic [NET_MSG_W-1:0] msg;
        logic [NET_MSG_W-1:0] m1;
        logic [NET_MSG_W-1:0] m2;
        int low;
        msg = rand_msg(2'd3);
        msg[7:0] = 8'hAB;
        drive(1'b1, msg, 1'b0);
        tests_run++; if (bus.NETREQ !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_early: got %b expected 0", bus.NETREQ); end
        drive(1'b0, '0, 1'b0);
        tests_run++; if (bus.NETREQ !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_netreq: got %b expected 1", bus.NETREQ); end
        tests_run++; if (bus.NETPARAM !== msg) begin tests_failed++; $display("[TB] FAIL single_param: got %h expected %h", bus.NETPARAM, msg); end
        repeat (3) drive(1'b0, '0, 1'b0);
        tests_run++; if (bus.NETPARAM !== msg || bus.NETREQ !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_stable: got %h/%b expected %h/1", bus.NETPARAM, bus.NETREQ, msg); end
        drive(1'b0, '0, 1'b1);
        tests_run++; if (bus.NETREQ !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_after_rd: got %b expected 0", bus.NETREQ); end
        drive(1'b0, '0, 1'b0);
        tests_run++; if (bus.NETREQ !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_no_more: got %b expected 0", bus.NETREQ); end

        m1 = rand_msg(2'd3);
        m2 = rand_msg(2'd3);
        drive(1'b1, m1, 1'b0);
        drive(1'b1, m2, 1'b0);
        drive(1'b0, '0, 1'b1);
        low = 0;
        for (int i = 0; i < 10 && bus.NETREQ !== 1'b1; i++) begin
            low++;
            drive(1'b0, '0, 1'b0);
        end
        tests_run++; if (low != 2) begin tests_failed++; $display("[TB] FAIL b2b_gap: got %0d low cycles expected 2", low); end
        tests_run++; if (bus.NETPARAM !== m2) begin tests_failed++; $display("[TB] FAIL b2b_param: got %h expected %h", bus.NETPARAM, m2); end
        drive(1'b0, '0, 1'b1);
    endtask

    logic [NET_MSG_W-1:0] ovf_msgs[10];
    logic [NET_MSG_W-1:0] ovf_extra;

    task automatic test_overflow();
        int pulses;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            ovf_msgs[i] = rand_msg(2'd3);
            drive(1'b1, ovf_msgs[i], 1'b0);
            if (bus.OVFL === 1'b1) pulses++;
        end
        tests_run++; if (bus.NETPARAM !== ovf_msgs[0]) begin tests_failed++; $display("[TB] FAIL ovf_head: got %h expected %h", bus.NETPARAM, ovf_msgs[0]); end
        tests_run++; if (bus.LEVEL !== LW'(8)) begin tests_failed++; $display("[TB] FAIL ovf_level: got %0d expected 8", bus.LEVEL); end
        tests_run++; if (bus.INRDY !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_inrdy: got %b expected 0", bus.INRDY); end
        tests_run++; if (bus.DROPCNT !== 8'd1) begin tests_failed++; $display("[TB] FAIL ovf_dropcnt: got %0d expected 1", bus.DROPCNT); end
        drive(1'b0, '0, 1'b0);
        tests_run++; if (pulses != 1 || bus.OVFL !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_pulse: got %0d pulses, ovfl now %b, expected 1 pulse then 0", pulses, bus.OVFL); end
    endtask

    task automatic test_full_load();
        logic [NET_MSG_W-1:0] expq[$];
        int waitc;
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
        ovf_extra = rand_msg(2'd3);
        drive(1'b1, ovf_extra, 1'b0);
        tests_run++; if (bus.LEVEL !== LW'(8)) begin tests_failed++; $display("[TB] FAIL fullload_level: got %0d expected 8", bus.LEVEL); end
        tests_run++; if (bus.OVFL !== 1'b0 || bus.DROPCNT !== 8'd1) begin tests_failed++; $display("[TB] FAIL fullload_ovfl: got ovfl %b dropcnt %0d expected 0 and 1", bus.OVFL, bus.DROPCNT); end
        tests_run++; if (bus.NETPARAM !== ovf_msgs[1] || bus.NETREQ !== 1'b1) begin tests_failed++; $display("[TB] FAIL fullload_head: got %h expected %h", bus.NETPARAM, ovf_msgs[1]); end
        drive(1'b0, '0, 1'b1);
        for (int i = 2; i < 9; i++) expq.push_back(ovf_msgs[i]);
        expq.push_back(ovf_extra);
        foreach (expq[k]) begin
            waitc = 0;
            while (bus.NETREQ !== 1'b1 && waitc < 8) begin
                drive(1'b0, '0, 1'b0);
                waitc++;
            end
            tests_run++; if (bus.NETREQ !== 1'b1 || bus.NETPARAM !== expq[k]) begin tests_failed++; $display("[TB] FAIL drain_order[%0d]: got %h/%b expected %h/1", k, bus.NETPARAM, bus.NETREQ, expq[k]); end
            drive(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_ignored_rd();
        logic [NET_MSG_W-1:0] x;
        logic [NET_MSG_W-1:0] y;
        do_reset();
        x = rand_msg(2'd3);
        y = rand_msg(2'd3);
        drive(1'b0, '0, 1'b1);
        tests_run++; if (bus.NETREQ !== 1'b0 || bus.LEVEL !== LW'(0)) begin tests_failed++; $display("[TB] FAIL idle_rd_empty: got %b/%0d expected 0/0", bus.NETREQ, bus.LEVEL); end
        drive(1'b1, x, 1'b1);
        drive(1'b1, y, 1'b1);
        tests_run++; if (bus.NETREQ !== 1'b1 || bus.NETPARAM !== x || bus.LEVEL !== LW'(1)) begin tests_failed++; $display("[TB] FAIL idle_rd_load: got %h/%b/%0d expected %h/1/1", bus.NETPARAM, bus.NETREQ, bus.LEVEL, x); end
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        tests_run++; if (bus.NETREQ !== 1'b0 || bus.LEVEL !== LW'(1)) begin tests_failed++; $display("[TB] FAIL gap_rd: got %b/%0d expected 0/1", bus.NETREQ, bus.LEVEL); end
        drive(1'b0, '0, 1'b1);
        tests_run++; if (bus.NETREQ !== 1'b1 || bus.NETPARAM !== y || bus.LEVEL !== LW'(0)) begin tests_failed++; $display("[TB] FAIL idle_rd_next: got %h/%b/%0d expected %h/1/0", bus.NETPARAM, bus.NETREQ, bus.LEVEL, y); end
        drive(1'b0, '0, 1'b0);
        tests_run++; if (bus.NETREQ !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_rd_kept: got %b expected 1", bus.NETREQ); end
    endtask

    task automatic test_priority_order();
        logic [NET_MSG_W-1:0] expq[$];
        int waitc;
        do_reset();
        expq.push_back(rand_msg(2'd3));
        expq.push_back(rand_msg(2'd0));
        expq.push_back(rand_msg(2'd3));
        drive(1'b1, expq[0], 1'b0);
        drive(1'b0, '0, 1'b0);
        drive(1'b1, expq[1], 1'b0);
        tests_run++; if (bus.NETPARAM !== expq[0]) begin tests_failed++; $display("[TB] FAIL prio_hold_b: got %h expected %h", bus.NETPARAM, expq[0]); end
        drive(1'b1, expq[2], 1'b0);
        tests_run++; if (bus.NETPARAM !== expq[0] || bus.NETREQ !== 1'b1) begin tests_failed++; $display("[TB] FAIL prio_hold_c: got %h/%b expected %h/1", bus.NETPARAM, bus.NETREQ, expq[0]); end
        foreach (expq[k]) begin
            waitc = 0;
            while (bus.NETREQ !== 1'b1 && waitc < 8) begin
                drive(1'b0, '0, 1'b0);
                waitc++;
            end
            tests_run++; if (bus.NETREQ !== 1'b1 || bus.NETPARAM !== expq[k]) begin tests_failed++; $display("[TB] FAIL prio_order[%0d]: got %h/%b expected %h/1", k, bus.NETPARAM, bus.NETREQ, expq[k]); end
            drive(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 9 + 260; i++) drive(1'b1, rand_msg(2'd3), 1'b0);
        tests_run++; if (bus.DROPCNT !== 8'd255) begin tests_failed++; $display("[TB] FAIL sat_dropcnt: got %0d expected 255", bus.DROPCNT); end
        tests_run++; if (bus.OVFL !== 1'b1 || bus.LEVEL !== LW'(8)) begin tests_failed++; $display("[TB] FAIL sat_ovfl_level: got %b/%0d expected 1/8", bus.OVFL, bus.LEVEL); end
    endtask

    task automatic test_reset_mid();
        logic [NET_MSG_W-1:0] z;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1);
            drive(1'b0, '0, 1'b0);
            drive(1'b0, '0, 1'b0);
        end
        tests_run++; if (bus.LEVEL !== LW'(5) || bus.NETREQ !== 1'b1 || bus.DROPCNT !== 8'd255) begin tests_failed++; $display("[TB] FAIL rstmid_pre: got %0d/%b/%0d expected 5/1/255", bus.LEVEL, bus.NETREQ, bus.DROPCNT); end
        #3 RESETn = 1'b0;
        #1;
        tests_run++; if (bus.NETREQ !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_netreq: got %b expected 0", bus.NETREQ); end
        tests_run++; if (bus.LEVEL !== LW'(0) || bus.INRDY !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_level: got %0d/%b expected 0/1", bus.LEVEL, bus.INRDY); end
        tests_run++; if (bus.DROPCNT !== 8'd0 || bus.NETPARAM !== '0) begin tests_failed++; $display("[TB] FAIL rstmid_cnt_param: got %0d/%h expected 0/0", bus.DROPCNT, bus.NETPARAM); end
        model_reset();
        @(posedge CLK);
        #1 RESETn = 1'b1;
        z = rand_msg(2'd3);
        drive(1'b1, z, 1'b0);
        tests_run++; if (bus.NETREQ !== 1'b0 || bus.LEVEL !== LW'(1)) begin tests_failed++; $display("[TB] FAIL rstmid_w1: got %b/%0d expected 0/1", bus.NETREQ, bus.LEVEL); end
        drive(1'b0, '0, 1'b0);
        tests_run++; if (bus.NETREQ !== 1'b1 || bus.NETPARAM !== z || bus.LEVEL !== LW'(0)) begin tests_failed++; $display("[TB] FAIL rstmid_w2: got %h/%b/%0d expected %h/1/0", bus.NETPARAM, bus.NETREQ, bus.LEVEL, z); end
    endtask

    task automatic test_random();
        bit wr;
        bit rd;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            wr = ($urandom_range(0, 99) < 60);
            rd = ($urandom_range(0, 99) < 30);
            drive(wr, rand_msg(2'($urandom_range(0, 3))), rd);
            tests_run++; if (bus.NETREQ !== m_present) begin tests_failed++; $display("[TB] FAIL rnd_netreq@%0d: got %b expected %b", i, bus.NETREQ, m_present); end
            tests_run++; if (bus.NETPARAM !== m_head) begin tests_failed++; $display("[TB] FAIL rnd_param@%0d: got %h expected %h", i, bus.NETPARAM, m_head); end
            tests_run++; if (bus.LEVEL !== LW'(mq.size()) || bus.INRDY !== (mq.size() != DEPTH)) begin tests_failed++; $display("[TB] FAIL rnd_level@%0d: got %0d/%b expected %0d", i, bus.LEVEL, bus.INRDY, mq.size()); end
            tests_run++; if (bus.OVFL !== m_ovfl || bus.DROPCNT !== 8'(m_drops)) begin tests_failed++; $display("[TB] FAIL rnd_drop@%0d: got %b/%0d expected %b/%0d", i, bus.OVFL, bus.DROPCNT, m_ovfl, m_drops); end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.INSTB    = 1'b0;
        bus.NETMSGRD = 1'b0;
        bus.INDATA   = '0;
        test_reset();
        test_single();
        test_overflow();
        test_full_load();
        test_ignored_rd();
        test_priority_order();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
